// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Streaming K_H x K_W sliding-window generator (stride 1, no padding).
//   Takes one pixel per cycle in raster order and emits every complete window
//   through a registered output stage under a valid/ready handshake.
//
//   Ports
//     clk, rst        rising-edge clock, synchronous active-high reset
//     clr             synchronous frame restart (counters and win_valid only)
//     pix_valid/ready input pixel handshake, pix_data pixel value
//     win_valid/ready output window handshake
//     conv_win        window, conv_win[r][c]; [0][0] is top-left (oldest)
//     win_row/win_col top-left position of the emitted window
//     win_last        (CONV_WIN_LAST_EN only) marks the final window of a frame
//
//   Configuration macro: CONV_WIN_LAST_EN adds the win_last output.
module conv_window_gen #(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int DATA_WIDTH = 9,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clr,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [DATA_WIDTH-1:0]                      pix_data,
    output logic                                       win_valid,
    input  logic                                       win_ready,
    output logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0]    conv_win,
    output logic [$clog2(IMG_H)-1:0]                   win_row,
`ifdef CONV_WIN_LAST_EN
    output logic [$clog2(IMG_W)-1:0]                   win_col,
    output logic                                       win_last
`else
    output logic [$clog2(IMG_W)-1:0]                   win_col
`endif
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int unsigned NLB = K_H - 1;

    typedef logic [DATA_WIDTH-1:0]                   pix_t;
    typedef logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0] win_t;

    // lb_q[k] holds the row that is k+1 rows above the current row
    pix_t lb_q [NLB][IMG_W];
    pix_t lb_d [NLB][IMG_W];
    win_t sr_q, sr_d;
    pix_t col_vec [K_H];

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    win_t          conv_win_q, conv_win_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          win_last_q, win_last_d;
    logic          accept;
    logic          win_pos;

    always_comb begin
        pix_ready = !clr && (!win_valid_q || win_ready);
        accept    = pix_valid && pix_ready;
        win_pos   = (row_q >= RW'(K_H - 1)) && (col_q >= CW'(K_W - 1));

        // Vertical column ending at the incoming pixel, top row first
        for (int unsigned r = 0; r < NLB; r++) begin
            col_vec[r] = lb_q[NLB-1-r][col_q];
        end
        col_vec[K_H-1] = pix_data;

        lb_d = lb_q;
        sr_d = sr_q;
        if (accept) begin
            lb_d[0][col_q] = pix_data;
            for (int unsigned k = 1; k < NLB; k++) begin
                lb_d[k][col_q] = lb_q[k-1][col_q];
            end
            for (int unsigned r = 0; r < K_H; r++) begin
                for (int unsigned c = 0; c < K_W - 1; c++) begin
                    sr_d[r][c] = sr_q[r][c+1];
                end
                sr_d[r][K_W-1] = col_vec[r];
            end
        end

        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        win_valid_d = win_valid_q && !win_ready && !clr;
        conv_win_d  = conv_win_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        // Position test alone keeps row-straddling and stale previous-frame
        // shift/line-buffer contents from ever reaching the output.
        if (accept && win_pos) begin
            win_valid_d = 1'b1;
            conv_win_d  = sr_d;
            win_row_d   = row_q - RW'(K_H - 1);
            win_col_d   = col_q - CW'(K_W - 1);
            win_last_d  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            conv_win_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            conv_win_q  <= conv_win_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_last_q  <= win_last_d;
        end
    end

    // Data storage needs no reset: only windows fully inside the frame are emitted
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
        sr_q <= sr_d;
    end

    assign win_valid = win_valid_q;
    assign conv_win  = conv_win_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
`ifdef CONV_WIN_LAST_EN
    assign win_last  = win_last_q;
`else
    logic unused_last;
    assign unused_last = win_last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Scoreboard bench for conv_window_gen on a 4x4 frame with a 3x3 window.
//   Expected windows are built from a bench-side copy of the frame and pushed
//   on pixel acceptance; the output monitor pops and compares on handshake.
module tb_conv_window_gen;

    localparam int K_H   = 3;
    localparam int K_W   = 3;
    localparam int DW    = 9;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);

    typedef logic [K_H-1:0][K_W-1:0][DW-1:0] win_t;
    typedef struct {
        logic [127:0] win;
        int           row;
        int           col;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, clr, pix_valid, pix_ready, win_valid, win_ready;
    logic [DW-1:0] pix_data;
    win_t          conv_win;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_last;

    conv_window_gen #(
        .K_H(K_H), .K_W(K_W), .DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .conv_win(conv_win), .win_row(win_row),
`ifdef CONV_WIN_LAST_EN
        .win_col(win_col), .win_last(win_last)
`else
        .win_col(win_col)
`endif
    );
`ifndef CONV_WIN_LAST_EN
    assign win_last = 1'b0;
`endif

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   win_cnt = 0;
    exp_t q[$];
    int   mem [IMG_H][IMG_W];
    int   m_row = 0;
    int   m_col = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] closed_win(int r0, int c0, int off);
        win_t w;
        for (int r = 0; r < K_H; r++)
            for (int c = 0; c < K_W; c++)
                w[r][c] = DW'(IMG_W * (r0 + r) + (c0 + c) + off);
        return 128'(w);
    endfunction

    task automatic model_accept(input int d);
        exp_t e;
        win_t w;
        mem[m_row][m_col] = d;
        if (m_row >= K_H - 1 && m_col >= K_W - 1) begin
            for (int r = 0; r < K_H; r++)
                for (int c = 0; c < K_W; c++)
                    w[r][c] = DW'(mem[m_row-K_H+1+r][m_col-K_W+1+c]);
            e.win  = 128'(w);
            e.row  = m_row - K_H + 1;
            e.col  = m_col - K_W + 1;
            e.last = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
            q.push_back(e);
        end
        if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // One clock cycle; entered and left at the falling edge.
    task automatic cycle(input logic v, input int d, output logic acc);
        pix_valid = v;
        pix_data  = DW'(d);
        #1;
        acc = v && pix_ready && !rst;
        @(posedge clk);
        if (acc) model_accept(d);
        if (rst || clr) begin
            m_row = 0;
            m_col = 0;
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic send_pixel(input int d);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, d, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 128'(0), 128'(1));
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        rst = 1'b1;
        cycle(1'b0, 0, acc);
        cycle(1'b0, 0, acc);
        rst = 1'b0;
        check("rst_win_valid", 128'(win_valid), 128'(0));
        check("rst_conv_win", 128'(conv_win), 128'(0));
        check("rst_win_row", 128'(win_row), 128'(0));
        check("rst_win_col", 128'(win_col), 128'(0));
        check("rst_pix_ready", 128'(pix_ready), 128'(1));
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            send_pixel(base + i);
            if (i == 2 * IMG_W + 2) begin
                check("first_win", 128'(conv_win), closed_win(0, 0, base));
                check("first_row", 128'(win_row), 128'(0));
                check("first_col", 128'(win_col), 128'(0));
            end
            if (i == IMG_W * IMG_H - 1) begin
                check("last_win", 128'(conv_win), closed_win(1, 1, base));
                check("last_row", 128'(win_row), 128'(1));
                check("last_col", 128'(win_col), 128'(1));
            end
        end
    endtask

    task automatic drain_and_count(input string tag, input int start, input int n);
        idle(3);
        check(tag, 128'(win_cnt - start), 128'(n));
        check("queue_empty", 128'(q.size()), 128'(0));
    endtask

    // Output monitor, sampling mid-low-phase when all inputs have settled
    logic          prev_stall = 1'b0;
    win_t          prev_win;
    logic [RW-1:0] prev_row;
    logic [CW-1:0] prev_col;

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && win_valid) begin
                check("hold_win", 128'(conv_win), 128'(prev_win));
                check("hold_row", 128'(win_row), 128'(prev_row));
                check("hold_col", 128'(win_col), 128'(prev_col));
            end
            if (win_valid && win_ready) begin
                win_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_win", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    check("sb_win", 128'(conv_win), e.win);
                    check("sb_row", 128'(win_row), 128'(e.row));
                    check("sb_col", 128'(win_col), 128'(e.col));
`ifdef CONV_WIN_LAST_EN
                    check("sb_last", 128'(win_last), 128'(e.last));
`endif
                end
            end
            prev_stall = win_valid && !win_ready;
            prev_win   = conv_win;
            prev_row   = win_row;
            prev_col   = win_col;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        logic acc;
        rst = 1'b1; clr = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
        @(negedge clk);

        // Single frame
        do_reset();
        start = win_cnt;
        send_frame(0);
        drain_and_count("s1_windows", start, 4);

        // Consumer stall after first window
        do_reset();
        start = win_cnt;
        for (int i = 0; i <= 2 * IMG_W + 2; i++) send_pixel(i);
        win_ready = 1'b0;
        check("stall_valid", 128'(win_valid), 128'(1));
        for (int s = 0; s < 5; s++) begin
            pix_valid = 1'b1;
            pix_data  = DW'(2 * IMG_W + 3);
            #1;
            check("stall_ready", 128'(pix_ready), 128'(0));
            @(posedge clk);
            @(negedge clk);
        end
        check("stall_row", 128'(win_row), 128'(0));
        check("stall_col", 128'(win_col), 128'(0));
        win_ready = 1'b1;
        for (int i = 2 * IMG_W + 3; i < IMG_W * IMG_H; i++) send_pixel(i);
        drain_and_count("s2_windows", start, 4);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 6; i++) send_pixel(100 + i);
        do_reset();
        start = win_cnt;
        send_frame(0);
        drain_and_count("s3_windows", start, 4);

        // clr with pixel offered the same cycle, pending window discarded
        do_reset();
        for (int i = 0; i <= 2 * IMG_W + 2; i++) send_pixel(200 + i);
        win_ready = 1'b0;
        clr = 1'b1;
        pix_valid = 1'b1;
        pix_data = DW'(99);
        #1;
        check("clr_ready", 128'(pix_ready), 128'(0));
        pix_valid = 1'b0;
        @(posedge clk);
        m_row = 0; m_col = 0; q.delete();
        @(negedge clk);
        clr = 1'b0;
        check("clr_win_valid", 128'(win_valid), 128'(0));
        win_ready = 1'b1;
        start = win_cnt;
        send_frame(0);
        drain_and_count("s4_windows", start, 4);

        // Two back-to-back frames
        do_reset();
        start = win_cnt;
        send_frame(0);
        send_frame(IMG_W * IMG_H);
        drain_and_count("s5_windows", start, 8);

        // Randomised valid/ready pattern over two frames
        do_reset();
        start = win_cnt;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < IMG_W * IMG_H; i++) begin
                acc = 1'b0;
                for (int t = 0; t < 40 && !acc; t++) begin
                    win_ready = ($urandom_range(0, 3) != 0);
                    cycle(($urandom_range(0, 2) != 0), 50 + f * 16 + i, acc);
                end
                if (!acc) check("rand_timeout", 128'(0), 128'(1));
            end
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        drain_and_count("rand_windows", start, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
